// File: rtl/game_round_ctrl_if.sv
// Player handshake and Decision comparator signals of the round controller.
// The controller uses the slave modport; players and Decision form the master side.
interface game_round_ctrl_if;
  logic       P0_valid;
  logic       P1_valid;
  logic [1:0] P0_guess;
  logic [1:0] P1_guess;
  logic       P0_ready;
  logic       P1_ready;
  logic [1:0] Out_wr;
  logic [1:0] Correct_guess;
  logic [1:0] Result;

  modport master (
    output P0_valid, P0_guess, P1_valid, P1_guess, Result,
    input  P0_ready, P1_ready, Out_wr, Correct_guess
  );

  modport slave (
    input  P0_valid, P0_guess, P1_valid, P1_guess, Result,
    output P0_ready, P1_ready, Out_wr, Correct_guess
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Two-player guessing-game sequencer around a shared Decision comparator.
// Optional per-round guess timeout (and the TIMEOUT parameter) exists only with GAME_TIMEOUT_EN.
module game_round_ctrl #(
  parameter int ROUNDS  = 8,
  parameter int SCORE_W = 4,
  parameter int DEC_LAT = 1
`ifdef GAME_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [1:0]         Secret,
  game_round_ctrl_if.slave   bus,
  output logic [SCORE_W-1:0] Score0,
  output logic [SCORE_W-1:0] Score1,
  output logic [7:0]         Round,
  output logic               Busy,
  output logic               Done,
  output logic [1:0]         Winner
`ifdef GAME_TIMEOUT_EN
  , output logic [1:0]       Timeout_flag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_SCORE, S_DONE
  } state_t;

  state_t             state_q;
  logic               ptr_q, cur_q, second_q;
  logic               h0_q, h1_q, rdy0_q, rdy1_q;
  logic [1:0]         g0_q, g1_q, res_q, out_wr_q, cg_q, winner_q;
  logic [1:0]         cnt_q;
  logic [SCORE_W-1:0] sc0_q, sc1_q, sc0_d, sc1_d;
  logic [7:0]         round_q;
  logic               busy_q, done_q;
  logic               nxt_p, nxt_skip;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  function automatic logic [1:0] win_of(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  // Player to evaluate next: round leader on leaving COLLECT, otherwise the other one.
  assign nxt_p = (state_q == S_COLLECT) ? ptr_q : ~cur_q;

`ifdef GAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  logic [TO_W-1:0] to_cnt_q;
  logic [1:0]      to_q;
  logic            tmo;
  assign tmo          = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign nxt_skip     = to_q[nxt_p];
  assign Timeout_flag = to_q;
`else
  assign nxt_skip = 1'b0;
`endif

  always_comb begin
    sc0_d = sc0_q;
    sc1_d = sc1_q;
    if (res_q == 2'b01) begin
      if (cur_q) sc1_d = sat_inc(sc1_q);
      else       sc0_d = sat_inc(sc0_q);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      cur_q    <= 1'b0;
      second_q <= 1'b0;
      h0_q     <= 1'b0;
      h1_q     <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      g0_q     <= '0;
      g1_q     <= '0;
      res_q    <= '0;
      out_wr_q <= '0;
      cg_q     <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      sc0_q    <= '0;
      sc1_q    <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef GAME_TIMEOUT_EN
      to_cnt_q <= '0;
      to_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q  <= S_COLLECT;
            ptr_q    <= 1'b0;
            sc0_q    <= '0;
            sc1_q    <= '0;
            round_q  <= '0;
            winner_q <= '0;
            cg_q     <= Secret;
            h0_q     <= 1'b0;
            h1_q     <= 1'b0;
            rdy0_q   <= 1'b1;
            rdy1_q   <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef GAME_TIMEOUT_EN
            to_cnt_q <= '0;
            to_q     <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (h0_q && h1_q) begin
            second_q <= 1'b0;
            cur_q    <= nxt_p;
            if (nxt_skip) begin
              state_q <= S_SCORE;
              res_q   <= 2'b10;
            end else begin
              state_q  <= S_ISSUE;
              out_wr_q <= nxt_p ? g1_q : g0_q;
            end
          end else begin
            if (rdy0_q && bus.P0_valid) begin
              g0_q   <= bus.P0_guess;
              h0_q   <= 1'b1;
              rdy0_q <= 1'b0;
            end
`ifdef GAME_TIMEOUT_EN
            else if (tmo && !h0_q) begin
              h0_q    <= 1'b1;
              rdy0_q  <= 1'b0;
              to_q[0] <= 1'b1;
            end
`endif
            if (rdy1_q && bus.P1_valid) begin
              g1_q   <= bus.P1_guess;
              h1_q   <= 1'b1;
              rdy1_q <= 1'b0;
            end
`ifdef GAME_TIMEOUT_EN
            else if (tmo && !h1_q) begin
              h1_q    <= 1'b1;
              rdy1_q  <= 1'b0;
              to_q[1] <= 1'b1;
            end
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= 2'(DEC_LAT - 1);
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            res_q    <= bus.Result;
            out_wr_q <= '0;
            state_q  <= S_SCORE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_SCORE: begin
          sc0_q <= sc0_d;
          sc1_q <= sc1_d;
          if (!second_q) begin
            second_q <= 1'b1;
            cur_q    <= nxt_p;
            if (nxt_skip) begin
              res_q <= 2'b10;
            end else begin
              state_q  <= S_ISSUE;
              out_wr_q <= nxt_p ? g1_q : g0_q;
            end
          end else if (round_q == 8'(ROUNDS - 1)) begin
            round_q  <= round_q + 8'd1;
            state_q  <= S_DONE;
            winner_q <= win_of(sc0_d, sc1_d);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            round_q  <= round_q + 8'd1;
            state_q  <= S_COLLECT;
            ptr_q    <= ~ptr_q;
            cg_q     <= Secret;
            h0_q     <= 1'b0;
            h1_q     <= 1'b0;
            rdy0_q   <= 1'b1;
            rdy1_q   <= 1'b1;
`ifdef GAME_TIMEOUT_EN
            to_cnt_q <= '0;
            to_q     <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.P0_ready      = rdy0_q;
  assign bus.P1_ready      = rdy1_q;
  assign bus.Out_wr        = out_wr_q;
  assign bus.Correct_guess = cg_q;
  assign Score0            = sc0_q;
  assign Score1            = sc1_q;
  assign Round             = round_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign Winner            = winner_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized self-checking bench for game_round_ctrl with a game-level reference model
// and a behavioural Decision comparator; timeout scenario only with GAME_TIMEOUT_EN.
module tb_game_round_ctrl;
  localparam int ROUNDS  = 5;
  localparam int SCORE_W = 2;
  localparam int DEC_LAT = 2;
  localparam int PER     = DEC_LAT + 2;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  logic               Clock = 1'b0;
  logic               Reset_n = 1'b0;
  logic               Start = 1'b0;
  logic [1:0]         Secret = 2'b00;
  logic [SCORE_W-1:0] Score0, Score1;
  logic [7:0]         Round;
  logic               Busy, Done;
  logic [1:0]         Winner;
`ifdef GAME_TIMEOUT_EN
  logic [1:0]         Timeout_flag;
`endif

  game_round_ctrl_if bus();

  game_round_ctrl #(
    .ROUNDS(ROUNDS), .SCORE_W(SCORE_W), .DEC_LAT(DEC_LAT)
`ifdef GAME_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Secret(Secret), .bus(bus),
    .Score0(Score0), .Score1(Score1), .Round(Round), .Busy(Busy), .Done(Done),
    .Winner(Winner)
`ifdef GAME_TIMEOUT_EN
    , .Timeout_flag(Timeout_flag)
`endif
  );

  always #5 Clock = ~Clock;

  // Decision model: Result reflects the guess driven two cycles earlier; misses use any non-01 code.
  logic [1:0] wr_d1, cg_d1;
  logic [1:0] miss_tab [3] = '{2'b10, 2'b00, 2'b11};
  always @(posedge Clock) begin
    wr_d1      <= bus.Out_wr;
    cg_d1      <= bus.Correct_guess;
    bus.Result <= (wr_d1 == cg_d1) ? 2'b01 : miss_tab[$urandom_range(0, 2)];
  end

  int checks = 0;
  int errors = 0;
  int sec [ROUNDS];
  int ga  [ROUNDS];
  int gb  [ROUNDS];
  int da  [ROUNDS];
  int db  [ROUNDS];

  task automatic play_game(input string nm, input int abort_round, input int poke_round);
    int s0, s1, first, c, gf, gs;
    bit acc0, acc1;
    logic [1:0]  ew, exp_wr;
    logic [17:0] gv, ev;
    s0 = 0; s1 = 0;
    @(negedge Clock); Start = 1'b1; Secret = 2'(sec[0]);
    @(negedge Clock); Start = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      first = r % 2;
      gv = {Round, bus.Correct_guess, Busy, Done, bus.P0_ready, bus.P1_ready, Score0, Score1};
      ev = {8'(r), 2'(sec[r]), 1'b1, 1'b0, 1'b1, 1'b1, SCORE_W'(s0), SCORE_W'(s1)};
      checks++;
      if (gv !== ev) begin
        errors++; $display("FAIL %s round_start r=%0d got %h exp %h", nm, r, gv, ev);
      end
      acc0 = 0; acc1 = 0; c = 0;
      while (!(acc0 && acc1)) begin
        bus.P0_valid = (c >= da[r]);
        bus.P1_valid = (c >= db[r]);
        bus.P0_guess = acc0 ? 2'($urandom) : 2'(ga[r]);
        bus.P1_guess = acc1 ? 2'($urandom) : 2'(gb[r]);
        Start = (r == poke_round && c == 0);
        checks++;
        if ({bus.P0_ready, bus.P1_ready, bus.Out_wr} !== {!acc0, !acc1, 2'b00}) begin
          errors++;
          $display("FAIL %s collect r=%0d c=%0d ready/out got %b exp %b", nm, r, c,
                   {bus.P0_ready, bus.P1_ready, bus.Out_wr}, {!acc0, !acc1, 2'b00});
        end
        @(posedge Clock);
        if (bus.P0_valid) acc0 = 1;
        if (bus.P1_valid) acc1 = 1;
        @(negedge Clock);
        c++;
      end
      Start = 1'b0;
      bus.P0_valid = 1'b0; bus.P1_valid = 1'b0;
      if (r + 1 < ROUNDS) Secret = 2'(sec[r + 1]);
      gf = first ? gb[r] : ga[r];
      gs = first ? ga[r] : gb[r];
      for (int k = 0; k <= 2 * PER; k++) begin
        if (k >= 1 && k <= 1 + DEC_LAT)             exp_wr = 2'(gf);
        else if (k >= 1 + PER && k <= 1 + PER + DEC_LAT) exp_wr = 2'(gs);
        else                                        exp_wr = 2'b00;
        checks++;
        if (bus.Out_wr !== exp_wr) begin
          errors++; $display("FAIL %s out_wr r=%0d k=%0d got %b exp %b", nm, r, k, bus.Out_wr, exp_wr);
        end
        if (r == abort_round && k == 2) begin
          #2 Reset_n = 1'b0;
          #1;
          checks++;
          if ({Score0, Score1, Round, Busy, Done, Winner, bus.Out_wr, bus.Correct_guess,
               bus.P0_ready, bus.P1_ready} !== '0) begin
            errors++;
            $display("FAIL %s async_reset got %h exp 0", nm, {Score0, Score1, Round, Busy, Done,
                     Winner, bus.Out_wr, bus.Correct_guess, bus.P0_ready, bus.P1_ready});
          end
          @(negedge Clock); Reset_n = 1'b1;
          return;
        end
        if (k == PER + 1) begin
          if (first == 0 && ga[r] == sec[r]) s0 = (s0 < SMAX) ? s0 + 1 : SMAX;
          if (first == 1 && gb[r] == sec[r]) s1 = (s1 < SMAX) ? s1 + 1 : SMAX;
          checks++;
          if ({Score0, Score1} !== {SCORE_W'(s0), SCORE_W'(s1)}) begin
            errors++; $display("FAIL %s mid_score r=%0d got %0d/%0d exp %0d/%0d", nm, r, Score0, Score1, s0, s1);
          end
        end
        @(negedge Clock);
      end
      if (first == 1 && ga[r] == sec[r]) s0 = (s0 < SMAX) ? s0 + 1 : SMAX;
      if (first == 0 && gb[r] == sec[r]) s1 = (s1 < SMAX) ? s1 + 1 : SMAX;
    end
    ew = (s0 > s1) ? 2'b01 : (s1 > s0) ? 2'b10 : 2'b11;
    for (int h = 0; h < 2; h++) begin
      gv = {Done, Busy, Winner, Round, Score0, Score1, bus.Out_wr};
      ev = {1'b1, 1'b0, ew, 8'(ROUNDS), SCORE_W'(s0), SCORE_W'(s1), 2'b00};
      checks++;
      if (gv !== ev) begin
        errors++; $display("FAIL %s done h=%0d got %h exp %h", nm, h, gv, ev);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    bus.P0_valid = 0; bus.P1_valid = 0; bus.P0_guess = 0; bus.P1_guess = 0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({Score0, Score1, Round, Busy, Done, Winner, bus.Out_wr, bus.Correct_guess,
           bus.P0_ready, bus.P1_ready} !== '0) begin
        errors++;
        $display("FAIL reset_state i=%0d got %h exp 0", i, {Score0, Score1, Round, Busy, Done,
                 Winner, bus.Out_wr, bus.Correct_guess, bus.P0_ready, bus.P1_ready});
      end
      Reset_n = 1'b1;
      repeat (2) @(negedge Clock);
    end
  endtask

  task automatic test_p0_wins();
    for (int r = 0; r < ROUNDS; r++) begin
      sec[r] = 1; ga[r] = 1; gb[r] = 2; da[r] = 0; db[r] = 0;
    end
    play_game("p0_wins_sat", -1, -1);
  endtask

  task automatic test_ties();
    for (int r = 0; r < ROUNDS; r++) begin
      sec[r] = $urandom_range(0, 3); ga[r] = sec[r]; gb[r] = sec[r];
      da[r] = $urandom_range(0, 2); db[r] = $urandom_range(0, 2);
    end
    play_game("ties", -1, -1);
  endtask

  task automatic test_staggered();
    for (int r = 0; r < ROUNDS; r++) begin
      sec[r] = $urandom_range(0, 3); ga[r] = $urandom_range(0, 3); gb[r] = (ga[r] + 1) % 4;
      da[r] = $urandom_range(0, 1); db[r] = da[r] + 5;
    end
    play_game("staggered", -1, -1);
  endtask

  task automatic test_random(input int games);
    for (int g = 0; g < games; g++) begin
      for (int r = 0; r < ROUNDS; r++) begin
        sec[r] = $urandom_range(0, 3); ga[r] = $urandom_range(0, 3); gb[r] = $urandom_range(0, 3);
        da[r] = $urandom_range(0, 6); db[r] = $urandom_range(0, 6);
      end
      play_game("random", -1, (g == 0) ? 2 : -1);
    end
  endtask

  task automatic test_reset_midgame();
    for (int r = 0; r < ROUNDS; r++) begin
      sec[r] = $urandom_range(0, 3); ga[r] = $urandom_range(0, 3); gb[r] = $urandom_range(0, 3);
      da[r] = $urandom_range(0, 3); db[r] = $urandom_range(0, 3);
    end
    play_game("reset_midgame", 2, -1);
    test_random(1);
  endtask

`ifdef GAME_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.P0_valid = 1'b1; bus.P0_guess = 2'b01; bus.P1_valid = 1'b0;
    @(negedge Clock); Start = 1'b1; Secret = 2'b01;
    @(negedge Clock); Start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      checks++;
      if (Timeout_flag !== ((c >= 10) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL timeout_flag c=%0d got %b", c, Timeout_flag);
      end
      @(negedge Clock);
    end
    n = 0;
    while (!Done && n < 400) begin
      @(negedge Clock); n++;
    end
    bus.P0_valid = 1'b0;
    checks++;
    if ({Done, Score0, Score1, Winner, Timeout_flag} !== {1'b1, SCORE_W'(SMAX), SCORE_W'(0), 2'b01, 2'b10}) begin
      errors++;
      $display("FAIL timeout_game got done=%b s=%0d/%0d w=%b tf=%b", Done, Score0, Score1, Winner, Timeout_flag);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_p0_wins();
    test_ties();
    test_staggered();
    test_random(4);
    test_reset_midgame();
`ifdef GAME_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
